spi_txn_arbiter: RTL and testbench

Round-robin arbiter that shares one 16-bit SPI master command/response stream pair between NUM_REQ requesters, such as sensor drivers, a configuration sequencer or debug access. It accepts one command word from the winning requester and forwards it to the SPI master. It then routes the single returned response word back to that requester only. Exactly one transaction is in flight at a time. A response timeout keeps a dead device from locking out the other requesters.

---
 rtl/spi_txn_arbiter_if.sv | 36 +++
 rtl/spi_txn_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if
//   Bundles the requester command/response streams and the SPI master
//   command/response stream pair shared by spi_txn_arbiter.
//   Requester i occupies req_tdata[i*DATA_WIDTH +: DATA_WIDTH].
//   master : arbiter view (drives req_tready, rsp_*, spi_cmd_*, spi_rsp_tready)
//   slave  : requester/SPI-master view (drives the opposite directions)
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata;
    logic [NUM_REQ-1:0]            req_tvalid;
    logic [NUM_REQ-1:0]            req_tready;
    logic [DATA_WIDTH-1:0]         rsp_tdata;
    logic                          rsp_error;
    logic [NUM_REQ-1:0]            rsp_tvalid;
    logic [NUM_REQ-1:0]            rsp_tready;
    logic [DATA_WIDTH-1:0]         spi_cmd_tdata;
    logic                          spi_cmd_tvalid;
    logic                          spi_cmd_tready;
    logic [DATA_WIDTH-1:0]         spi_rsp_tdata;
    logic                          spi_rsp_tvalid;
    logic                          spi_rsp_tready;

    modport master (
        input  req_tdata, req_tvalid, rsp_tready, spi_cmd_tready, spi_rsp_tdata, spi_rsp_tvalid,
        output req_tready, rsp_tdata, rsp_error, rsp_tvalid, spi_cmd_tdata, spi_cmd_tvalid,
               spi_rsp_tready
    );

    modport slave (
        output req_tdata, req_tvalid, rsp_tready, spi_cmd_tready, spi_rsp_tdata, spi_rsp_tvalid,
        input  req_tready, rsp_tdata, rsp_error, rsp_tvalid, spi_cmd_tdata, spi_cmd_tvalid,
               spi_rsp_tready
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Round-robin arbiter sharing one SPI master command/response stream pair
//   between NUM_REQ requesters. One transaction in flight at a time; the
//   response is routed back to the granted requester only. A response
//   timeout (TIMEOUT_CYCLES, 0 = disabled) returns an error response so a
//   dead device cannot lock out other requesters.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   bus          : requester and SPI master streams (master modport)
//   grant_id     : current or most recently granted requester
//   busy         : arbiter is not idle
//   stray_count  : saturating count of responses discarded while idle
module spi_txn_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       reset,
    spi_txn_arbiter_if.master          bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [7:0]                 stray_count
);
    localparam int unsigned NR    = NUM_REQ;
    localparam int unsigned GW    = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;
    localparam logic [1:0] S_DELIVER  = 2'd3;

    logic [1:0]            state;
    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         win_idx;
    logic [GW-1:0]         cand;
    logic                  win_found;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  cmd_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [NUM_REQ-1:0]    req_rdy;

    // Round-robin scan starting just after the last delivered grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            cand = GW'((32'(last_grant) + k + 32'd1) % NR);
            if (!win_found && bus.req_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Ready is held low during reset even though the state register already reads IDLE.
    always_comb begin
        req_rdy = '0;
        if (state == S_IDLE && win_found && !reset) begin
            req_rdy[win_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_oh           = '0;
        grant_oh[grant_id] = 1'b1;
    end

    assign bus.req_tready     = req_rdy;
    assign bus.spi_cmd_tdata  = cmd_data;
    assign bus.spi_cmd_tvalid = cmd_valid;
    assign bus.rsp_tdata      = rsp_data;
    assign bus.rsp_error      = rsp_err;
    assign bus.rsp_tvalid     = rsp_valid;
    assign bus.spi_rsp_tready = (state == S_IDLE) || (state == S_WAIT_RSP);
    assign busy               = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            last_grant  <= GW'(NUM_REQ - 1);
            grant_id    <= '0;
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_valid   <= '0;
            stray_count <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Late responses (e.g. after a timeout) are accepted and dropped.
                    if (bus.spi_rsp_tvalid && stray_count != 8'hFF) begin
                        stray_count <= stray_count + 8'd1;
                    end
                    if (win_found) begin
                        cmd_data  <= bus.req_tdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        cmd_valid <= 1'b1;
                        grant_id  <= win_idx;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_valid && bus.spi_cmd_tready) begin
                        cmd_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    cnt <= cnt + CNT_W'(1);
                    // A response arriving on the timeout cycle takes priority.
                    if (bus.spi_rsp_tvalid) begin
                        rsp_data  <= bus.spi_rsp_tdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= grant_oh;
                        state     <= S_DELIVER;
                    end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= grant_oh;
                        state     <= S_DELIVER;
                    end
                end
                default: begin
                    if (|(rsp_valid & bus.rsp_tready)) begin
                        rsp_valid  <= '0;
                        last_grant <= grant_id;
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
`timescale 1ns/1ps
module tb_spi_txn_arbiter;
    localparam int NR = 2;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_txn_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifa ();
    spi_txn_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifb ();

    logic       gida, gidb, busya, busyb;
    logic [7:0] straya, strayb;

    spi_txn_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.master),
        .grant_id(gida), .busy(busya), .stray_count(straya));

    spi_txn_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.master),
        .grant_id(gidb), .busy(busyb), .stray_count(strayb));

    typedef struct { int unsigned idx; logic [15:0] data; logic err; } exp_t;
    typedef struct { logic [15:0] cmd; logic [15:0] rsp; int unsigned dly; } spi_t;

    exp_t        expa[$];
    exp_t        expb[$];
    spi_t        spiq[$];
    logic [15:0] rq0[$];
    logic [15:0] rq1[$];
    int          errors = 0;
    int          checks = 0;
    logic [1:0]  rdya = 2'b11;
    logic        cmd_rdy_a = 1'b1;

    assign ifa.rsp_tready     = rdya;
    assign ifa.spi_cmd_tready = cmd_rdy_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_a(input string t);
        chk({t, "_busy"}, busya, 0);
        chk({t, "_grant_id"}, gida, 0);
        chk({t, "_spi_cmd_tvalid"}, ifa.spi_cmd_tvalid, 0);
        chk({t, "_spi_cmd_tdata"}, ifa.spi_cmd_tdata, 0);
        chk({t, "_rsp_tvalid"}, ifa.rsp_tvalid, 0);
        chk({t, "_rsp_tdata"}, ifa.rsp_tdata, 0);
        chk({t, "_rsp_error"}, ifa.rsp_error, 0);
        chk({t, "_stray_count"}, straya, 0);
        chk({t, "_req_tready"}, ifa.req_tready, 0);
    endtask

    task automatic drain_a(input string nm);
        int n = 0;
        while ((expa.size() != 0 || busya) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_in_budget"}, n < 2000, 1);
    endtask

    // Requester driver for DUT A: presents queue fronts, pops on handshake.
    initial begin
        logic [1:0] hs;
        ifa.req_tvalid = '0;
        ifa.req_tdata  = '0;
        forever begin
            @(negedge clk);
            hs = ifa.req_tvalid & ifa.req_tready;
            @(posedge clk);
            #1;
            if (hs[0]) void'(rq0.pop_front());
            if (hs[1]) void'(rq1.pop_front());
            ifa.req_tvalid = {rq1.size() != 0, rq0.size() != 0};
            ifa.req_tdata  = {(rq1.size() != 0) ? rq1[0] : 16'h0, (rq0.size() != 0) ? rq0[0] : 16'h0};
        end
    end

    // SPI master model for DUT A: checks each command, replies after a delay.
    initial begin
        spi_t e;
        int   n;
        ifa.spi_rsp_tvalid = 1'b0;
        ifa.spi_rsp_tdata  = '0;
        forever begin
            @(negedge clk);
            if (!reset && ifa.spi_cmd_tvalid && ifa.spi_cmd_tready) begin
                if (spiq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spi_a_unexpected_cmd: got 0x%0h, expected no command", ifa.spi_cmd_tdata);
                end else begin
                    e = spiq.pop_front();
                    chk("spi_a_cmd", ifa.spi_cmd_tdata, e.cmd);
                    @(posedge clk);
                    repeat (e.dly) @(posedge clk);
                    #1;
                    ifa.spi_rsp_tvalid = 1'b1;
                    ifa.spi_rsp_tdata  = e.rsp;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!ifa.spi_rsp_tready && n < 200);
                    chk("spi_a_rsp_accepted", n < 200, 1);
                    @(posedge clk);
                    #1;
                    ifa.spi_rsp_tvalid = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitors: pop and compare on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (ifa.rsp_tvalid & ifa.rsp_tready) != 0) begin
                if (expa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_a_unexpected: rsp_tvalid=%b, expected none", ifa.rsp_tvalid);
                end else begin
                    e = expa.pop_front();
                    chk("rsp_a_route", ifa.rsp_tvalid, 32'(1) << e.idx);
                    chk("rsp_a_data", ifa.rsp_tdata, e.data);
                    chk("rsp_a_error", ifa.rsp_error, e.err);
                    chk("rsp_a_grant_id", gida, e.idx);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (ifb.rsp_tvalid & ifb.rsp_tready) != 0) begin
                if (expb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_b_unexpected: rsp_tvalid=%b, expected none", ifb.rsp_tvalid);
                end else begin
                    e = expb.pop_front();
                    chk("rsp_b_route", ifb.rsp_tvalid, 32'(1) << e.idx);
                    chk("rsp_b_data", ifb.rsp_tdata, e.data);
                    chk("rsp_b_error", ifb.rsp_error, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got time limit, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // Issue a B command on requester i and return at the negedge of its SPI handshake.
    task automatic b_issue(input int unsigned i, input logic [15:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        ifb.req_tdata = (i == 0) ? {16'h0, d} : {d, 16'h0};
        ifb.req_tvalid = (i == 0) ? 2'b01 : 2'b10;
        do begin @(negedge clk); n++; end while ((ifb.req_tready & ifb.req_tvalid) == 0 && n < 20);
        @(posedge clk);
        #1;
        ifb.req_tvalid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(ifb.spi_cmd_tvalid && ifb.spi_cmd_tready) && n < 20);
        chk("b_cmd_data", ifb.spi_cmd_tdata, d);
    endtask

    initial begin
        int n;
        ifb.req_tvalid = '0;
        ifb.req_tdata = '0;
        ifb.rsp_tready = 2'b11;
        ifb.spi_cmd_tready = 1'b1;
        ifb.spi_rsp_tvalid = 1'b0;
        ifb.spi_rsp_tdata = '0;

        // Power-on reset values
        repeat (3) @(negedge clk);
        chk_reset_a("por");
        chk("por_b_stray", strayb, 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Single requester, 40-cycle response
        rq0.push_back(16'hA000);
        spiq.push_back('{16'hA000, 16'h00E5, 40});
        expa.push_back('{0, 16'h00E5, 1'b0});
        n = 0;
        do begin @(negedge clk); n++; end while (!(ifa.req_tvalid[0] && ifa.req_tready[0]) && n < 20);
        chk("t1_req_hs_seen", n < 20, 1);
        @(negedge clk);
        chk("t1_cmd_valid_next", ifa.spi_cmd_tvalid, 1);
        chk("t1_cmd_data_next", ifa.spi_cmd_tdata, 16'hA000);
        drain_a("t1");

        // Contention out of reset: 0,1,0,1
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        rq0.push_back(16'h1100); rq0.push_back(16'h1101);
        rq1.push_back(16'h2200); rq1.push_back(16'h2201);
        spiq.push_back('{16'h1100, 16'hC000, 3});
        spiq.push_back('{16'h2200, 16'hC001, 5});
        spiq.push_back('{16'h1101, 16'hC002, 2});
        spiq.push_back('{16'h2201, 16'hC003, 4});
        expa.push_back('{0, 16'hC000, 1'b0});
        expa.push_back('{1, 16'hC001, 1'b0});
        expa.push_back('{0, 16'hC002, 1'b0});
        expa.push_back('{1, 16'hC003, 1'b0});
        drain_a("t2");

        // Delivery backpressure on requester 0
        rdya = 2'b10;
        rq0.push_back(16'h3300);
        rq1.push_back(16'h4400);
        spiq.push_back('{16'h3300, 16'hC100, 3});
        spiq.push_back('{16'h4400, 16'hC101, 3});
        expa.push_back('{0, 16'hC100, 1'b0});
        expa.push_back('{1, 16'hC101, 1'b0});
        n = 0;
        do begin @(negedge clk); n++; end while (ifa.rsp_tvalid == 0 && n < 200);
        chk("t3_rsp_seen", n < 200, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", ifa.rsp_tvalid, 2'b01);
            chk("t3_hold_data", ifa.rsp_tdata, 16'hC100);
            chk("t3_no_grant", ifa.req_tready, 2'b00);
        end
        @(posedge clk);
        #1 rdya = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("t3_next_grant_ready", ifa.req_tready, 2'b10);
        drain_a("t3");

        // Reset while ISSUE holds spi_cmd_tvalid
        cmd_rdy_a = 1'b0;
        rq1.push_back(16'h6600);
        n = 0;
        do begin @(negedge clk); n++; end while (!ifa.spi_cmd_tvalid && n < 20);
        chk("t4_issue_data", ifa.spi_cmd_tdata, 16'h6600);
        chk("t4_issue_grant", gida, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        rq0.push_back(16'h7700);
        rq1.push_back(16'h7701);
        spiq.push_back('{16'h7700, 16'hC200, 2});
        spiq.push_back('{16'h7701, 16'hC201, 2});
        expa.push_back('{0, 16'hC200, 1'b0});
        expa.push_back('{1, 16'hC201, 1'b0});
        cmd_rdy_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_reqs_pending", ifa.req_tvalid, 2'b11);
        chk_reset_a("mid_issue");
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("t4_first_grant_req0", ifa.req_tready, 2'b01);
        drain_a("t4");

        // Timeout on DUT B (TIMEOUT_CYCLES = 16)
        expb.push_back('{0, 16'h0000, 1'b1});
        b_issue(0, 16'h8800);
        n = 0;
        do begin @(negedge clk); n++; end while (ifb.rsp_tvalid == 0 && n < 100);
        chk("b_timeout_latency", n, 17);
        @(posedge clk);
        #1;
        ifb.spi_rsp_tvalid = 1'b1;
        ifb.spi_rsp_tdata = 16'h1234;
        @(negedge clk);
        chk("b_stray_ready_idle", ifb.spi_rsp_tready, 1);
        @(posedge clk);
        #1 ifb.spi_rsp_tvalid = 1'b0;
        @(negedge clk);
        chk("b_stray_count_1", strayb, 1);
        chk("b_stray_no_rsp", ifb.rsp_tvalid, 0);

        // Response on the timeout cycle wins (requester 1)
        expb.push_back('{1, 16'hBEEF, 1'b0});
        b_issue(1, 16'h9900);
        repeat (16) @(posedge clk);
        #1;
        ifb.spi_rsp_tvalid = 1'b1;
        ifb.spi_rsp_tdata = 16'hBEEF;
        @(negedge clk);
        chk("b_collide_ready", ifb.spi_rsp_tready, 1);
        @(posedge clk);
        #1 ifb.spi_rsp_tvalid = 1'b0;
        @(negedge clk);
        chk("b_collide_valid", ifb.rsp_tvalid, 2'b10);
        chk("b_collide_stray", strayb, 1);
        @(negedge clk);

        // Stray saturation
        @(posedge clk);
        #1 ifb.spi_rsp_tvalid = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (k == 253) chk("b_stray_254", strayb, 254);
            if (k == 254) chk("b_stray_255", strayb, 255);
            if (k == 300) chk("b_stray_sat", strayb, 255);
        end
        ifb.spi_rsp_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_sat_scoreboard_empty", expb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
